// File: rtl/rip_branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// rip_branch_resolve_queue
//
// In-order queue between rip_branch_predictor and the execute-stage branch
// unit. Each conditional branch's prediction snapshot (PHT index, counter
// weight, predicted direction) is captured at fetch. When execute resolves
// the oldest in-flight branch, a registered PHT write is issued back to the
// predictor and mispredictions are flagged. A mispredict or flush squashes
// every younger (wrong-path) entry.
//
// Optional feature macro: RIP_BRQ_FULL_BYPASS_EN
//   When defined, a full queue that is popping this cycle still accepts a
//   push (push_ready gains a combinational path from resolve_valid).
//
// Parameters:
//   INDEX_WIDTH  PHT index width
//   DEPTH        number of in-flight entries (power of two, >= 2)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_valid      fetch has a conditional branch to enqueue
//   push_ready      queue accepts a push this cycle
//   push_index      predictor index for the branch
//   push_weight     predictor counter value for the branch
//   push_pred       predicted direction (1 = taken)
//   resolve_valid   execute resolves the oldest branch
//   resolve_taken   actual direction
//   flush           squash all entries
//   update          PHT write strobe (registered)
//   update_index    PHT address for the write
//   update_weight   counter value read at prediction
//   actual          resolved direction
//   mispredict      one-cycle pulse, resolved != predicted
//   count           occupancy
//   underflow       sticky, resolve seen on an empty queue
// ---------------------------------------------------------------------------

package rip_bpw_pkg;
    typedef enum logic [1:0] {
        STRONGLY_UNTAKEN = 2'b00,
        WEAKLY_UNTAKEN   = 2'b01,
        WEAKLY_TAKEN     = 2'b10,
        STRONGLY_TAKEN   = 2'b11
    } rip_bpw_t;
endpackage

module rip_branch_resolve_queue
    import rip_bpw_pkg::*;
#(
    parameter int INDEX_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [INDEX_WIDTH-1:0]    push_index,
    input  rip_bpw_t                  push_weight,
    input  logic                      push_pred,
    input  logic                      resolve_valid,
    input  logic                      resolve_taken,
    input  logic                      flush,
    output logic                      update,
    output logic [INDEX_WIDTH-1:0]    update_index,
    output rip_bpw_t                  update_weight,
    output logic                      actual,
    output logic                      mispredict,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [INDEX_WIDTH-1:0] index_mem [DEPTH];
    rip_bpw_t               weight_mem [DEPTH];
    logic [DEPTH-1:0]       pred_mem;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;

    logic not_empty;
    logic do_pop;
    logic wrong_path;
    logic squash;
    logic do_push;

    assign not_empty = (count != '0);

`ifdef RIP_BRQ_FULL_BYPASS_EN
    // A full queue frees its head slot this cycle when it pops, so the
    // incoming branch can take that slot.
    assign push_ready = (count < DEPTH_CNT) | (resolve_valid & not_empty);
`else
    assign push_ready = (count < DEPTH_CNT);
`endif

    assign do_pop     = resolve_valid & not_empty;
    assign wrong_path = do_pop & (resolve_taken != pred_mem[rd_ptr]);
    // Anything younger than the resolving branch is wrong-path on a
    // mispredict, and everything is dropped on a flush; a same-cycle push
    // is younger still, so it is dropped too.
    assign squash     = wrong_path | flush;
    assign do_push    = push_valid & push_ready & ~squash;

    always_comb begin
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        count_next  = count;
        if (do_pop) begin
            rd_ptr_next = rd_ptr + PTR_W'(1);
        end
        if (squash) begin
            // Collapse the queue right behind the (possibly popped) head.
            wr_ptr_next = rd_ptr_next;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_next = count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_next = count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            update        <= 1'b0;
            update_index  <= '0;
            update_weight <= STRONGLY_UNTAKEN;
            actual        <= 1'b0;
            mispredict    <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            update     <= do_pop;
            mispredict <= wrong_path;
            if (do_pop) begin
                update_index  <= index_mem[rd_ptr];
                update_weight <= weight_mem[rd_ptr];
                actual        <= resolve_taken;
            end
            if (resolve_valid && !not_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: validity is tracked by the pointers
    // and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            index_mem[wr_ptr]  <= push_index;
            weight_mem[wr_ptr] <= push_weight;
            pred_mem[wr_ptr]   <= push_pred;
        end
    end

endmodule
